// File: rtl/perf_pkg.sv
// Shared definitions for the multi-core performance monitor: event encoding,
// default finish code and read-address field layout.
package perf_pkg;

  typedef enum logic [1:0] {
    EV_CYCLE   = 2'd0,
    EV_INSTRET = 2'd1,
    EV_BRPRED  = 2'd2,
    EV_BRMISP  = 2'd3
  } perf_event_e;

  localparam logic [31:0] FINI_CODE_DEFAULT = 32'h0002_0000;

  // Read address is {core, event, word}; word select sits in the LSB.
  localparam int WORD_POS  = 0;
  localparam int EVENT_LSB = 1;
  localparam int EVENT_W   = 2;
  localparam int CORE_LSB  = 3;

  function automatic int core_width(input int ncores);
    return (ncores <= 1) ? 1 : $clog2(ncores);
  endfunction

endpackage

// File: rtl/perf_cnt_bank.sv
// One core's cycle/instret/brpred/brmisp counters and sticky finish flag.
// With PERF_SNAPSHOT_EN defined, also holds a high-word shadow for atomic 64-bit reads.
module perf_cnt_bank
  import perf_pkg::*;
#(
  parameter int          CNT_W     = 64,
  parameter logic [31:0] FINI_CODE = FINI_CODE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             stall,
  input  logic             retire,
  input  logic             ctrl_tsfr,
  input  logic             br_misp,
  input  logic             fini_wvalid,
  input  logic [31:0]      fini_wdata,
`ifdef PERF_SNAPSHOT_EN
  input  logic             snap_latch,
  input  logic [1:0]       snap_event,
`endif
  output logic [3:0][31:0] lo_word,
  output logic [3:0][31:0] hi_word,
  output logic             fini
);

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic [CNT_W-1:0] brpred_cnt;
  logic [CNT_W-1:0] brmisp_cnt;
  logic             inc_instret;
  logic             inc_brpred;
  logic             inc_brmisp;
  logic [3:0][31:0] live_hi;

  assign inc_instret = retire && !stall;
  assign inc_brpred  = inc_instret && ctrl_tsfr;
  assign inc_brmisp  = inc_brpred && br_misp;

  // Clear beats any same-cycle increment or finish write; a finished core freezes.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      brpred_cnt  <= '0;
      brmisp_cnt  <= '0;
      fini        <= 1'b0;
    end else if (!fini) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (inc_instret) instret_cnt <= instret_cnt + CNT_W'(1);
      if (inc_brpred)  brpred_cnt  <= brpred_cnt + CNT_W'(1);
      if (inc_brmisp)  brmisp_cnt  <= brmisp_cnt + CNT_W'(1);
      if (fini_wvalid && (fini_wdata == FINI_CODE)) fini <= 1'b1;
    end
  end

  assign lo_word[EV_CYCLE]   = cycle_cnt[31:0];
  assign lo_word[EV_INSTRET] = instret_cnt[31:0];
  assign lo_word[EV_BRPRED]  = brpred_cnt[31:0];
  assign lo_word[EV_BRMISP]  = brmisp_cnt[31:0];

  // A 32-bit counter shifts down to zero, so its high word always reads 0.
  assign live_hi[EV_CYCLE]   = 32'(cycle_cnt >> 32);
  assign live_hi[EV_INSTRET] = 32'(instret_cnt >> 32);
  assign live_hi[EV_BRPRED]  = 32'(brpred_cnt >> 32);
  assign live_hi[EV_BRMISP]  = 32'(brmisp_cnt >> 32);

`ifdef PERF_SNAPSHOT_EN
  logic [31:0] shadow;
  logic        shadow_valid;
  logic [1:0]  shadow_event;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shadow       <= '0;
      shadow_valid <= 1'b0;
      shadow_event <= '0;
    end else if (snap_latch) begin
      shadow       <= live_hi[snap_event];
      shadow_valid <= 1'b1;
      shadow_event <= snap_event;
    end
  end

  always_comb begin
    hi_word = live_hi;
    for (int e = 0; e < 4; e++) begin
      if (shadow_valid && (shadow_event == 2'(e))) hi_word[e] = shadow;
    end
  end
`else
  assign hi_word = live_hi;
`endif

endmodule

// File: rtl/perf_monitor.sv
// Multi-core performance counters with a registered 1-cycle-latency read port.
// Optional PERF_SNAPSHOT_EN makes word-0 then word-1 reads return a consistent 64-bit pair.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int          NCORES    = 4,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] FINI_CODE = FINI_CODE_DEFAULT,
  localparam int         CW        = core_width(NCORES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic [NCORES-1:0]    stall_i,
  input  logic [NCORES-1:0]    retire_i,
  input  logic [NCORES-1:0]    ctrl_tsfr_i,
  input  logic [NCORES-1:0]    br_misp_i,
  input  logic [NCORES-1:0]    fini_wvalid_i,
  input  logic [32*NCORES-1:0] fini_wdata_i,
  input  logic                 rd_en_i,
  input  logic [CW+2:0]        rd_addr_i,
  output logic [31:0]          rd_data_o,
  output logic                 rd_valid_o,
  output logic [NCORES-1:0]    fini_o,
  output logic                 all_fini_o
);

  logic             rd_word;
  logic [1:0]       rd_event;
  logic [CW-1:0]    rd_core;
  logic [31:0]      rd_next;
  logic [3:0][31:0] bank_lo [NCORES];
  logic [3:0][31:0] bank_hi [NCORES];

  assign rd_word  = rd_addr_i[WORD_POS];
  assign rd_event = rd_addr_i[EVENT_LSB +: EVENT_W];
  assign rd_core  = rd_addr_i[CORE_LSB +: CW];

  for (genvar c = 0; c < NCORES; c++) begin : gen_bank
    perf_cnt_bank #(
      .CNT_W     (CNT_W),
      .FINI_CODE (FINI_CODE)
    ) u_bank (
      .clk         (clk_i),
      .rst         (rst_i),
      .clr         (clr_i),
      .stall       (stall_i[c]),
      .retire      (retire_i[c]),
      .ctrl_tsfr   (ctrl_tsfr_i[c]),
      .br_misp     (br_misp_i[c]),
      .fini_wvalid (fini_wvalid_i[c]),
      .fini_wdata  (fini_wdata_i[32*c +: 32]),
`ifdef PERF_SNAPSHOT_EN
      .snap_latch  (rd_en_i && !rd_word && (rd_core == CW'(c))),
      .snap_event  (rd_event),
`endif
      .lo_word     (bank_lo[c]),
      .hi_word     (bank_hi[c]),
      .fini        (fini_o[c])
    );
  end

  // Core indices with no bank never match, so they read back as zero.
  always_comb begin
    rd_next = '0;
    for (int c = 0; c < NCORES; c++) begin
      if (rd_core == CW'(c)) rd_next = rd_word ? bank_hi[c][rd_event] : bank_lo[c][rd_event];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_next;
    end
  end

  assign all_fini_o = &fini_o;

endmodule
